// File: rtl/sw_out_arb.sv
// Per-output-port round-robin arbiter and flit mux for the packet switch.
// Grants one requesting input at a time and forwards its flits until TAIL.
module sw_out_arb #(
  parameter  int NIN = 4,
  parameter  int W   = 32,
  localparam int IW  = $clog2(NIN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIN-1:0]       req,
  input  logic [2*NIN-1:0]     in_type,
  input  logic [W*NIN-1:0]     in_data,
  output logic [NIN-1:0]       ack,
  output logic                 out_valid,
  output logic [1:0]           out_type,
  output logic [W-1:0]         out_data,
  output logic                 busy,
  output logic [IW-1:0]        owner,
  output logic                 abort
);

  localparam logic [1:0] TYPE_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   owner_n;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   owner_inc;
  logic [1:0]      own_type;
  logic [W-1:0]    own_data;
  logic            own_req;
  logic            take;

  assign own_type  = in_type[2*owner +: 2];
  assign own_data  = in_data[W*owner +: W];
  assign own_req   = req[owner];
  assign owner_inc = (owner == IW'(NIN-1)) ? '0 : owner + 1'b1;
  assign busy      = (state != IDLE);

  // Round-robin scan starting at ptr; index wraps modulo NIN, which need not be a power of two.
  always_comb begin
    int   idx;
    logic found;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NIN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NIN) idx = idx - NIN;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    ack     = '0;
    abort   = 1'b0;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_n = winner;
          state_n = GRANT;
        end
      end
      GRANT: begin
        ack[owner] = 1'b1;
        take       = 1'b1;
        state_n    = XFER;
      end
      XFER: begin
        // TAIL wins over a dropped req: same-cycle drop is a normal completion.
        if (own_type == TYPE_TAIL) begin
          take    = 1'b1;
          ptr_n   = owner_inc;
          state_n = IDLE;
        end else if (!own_req) begin
          abort   = 1'b1;
          ptr_n   = owner_inc;
          state_n = IDLE;
        end else begin
          take    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
      // NOTE: the output payload register is reset too, so the port shows zeros after reset.
      out_type  <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      out_valid <= take;
      if (take) begin
        out_type <= own_type;
        out_data <= own_data;
      end
    end
  end

endmodule
